// File: rtl/alu_stream.sv
// alu_stream: handshaked ALU with registered result and {Z,C,N,O} flags, full or half precision.
// Defining ALU_MUL_EN compiles in the multi-cycle shift-add multiplier (FunSel 16).
module alu_stream #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             Half,
    input  logic             WF,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] HALF_MASK = {{H{1'b0}}, {H{1'b1}}};
    localparam logic [WIDTH-1:0] TOP_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TOP_HALF  = {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};

    logic [WIDTH-1:0] mask, top, a_m, b_m, b_op, res;
    logic [WIDTH:0]   sum;
    logic             cin, c_flag, carry, a_top, ovf;
    logic             is_arith, is_shift, reserved, shift_out;
    logic [3:0]       sc_flags;
    logic             accept, idle, is_mul;
    logic             mul_done, mul_wf;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] alu_out_d, alu_out_q;
    logic [3:0]       flags_d, flags_q;
    logic             out_valid_d, out_valid_q;

    assign InReady  = idle & (~out_valid_q | OutReady);
    assign accept   = InValid & InReady;
    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;
    assign OutValid = out_valid_q;
    assign c_flag   = flags_q[2];

    // Half mode works on the full-width datapath with the upper half masked off
    // and the sign/carry taps moved down to bit H-1 / H.
    always_comb begin
        mask      = Half ? HALF_MASK : '1;
        top       = Half ? TOP_HALF : TOP_FULL;
        a_m       = A & mask;
        b_m       = B & mask;
        a_top     = |(a_m & top);
        b_op      = (FunSel == 5'd6) ? (~B & mask) : b_m;
        cin       = (FunSel == 5'd5) ? c_flag : (FunSel == 5'd6);
        sum       = {1'b0, a_m} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        carry     = Half ? sum[H] : sum[WIDTH];
        is_arith  = 1'b0;
        is_shift  = 1'b0;
        reserved  = 1'b0;
        shift_out = 1'b0;
        res       = a_m;
        case (FunSel)
            5'd0:  res = a_m;
            5'd1:  res = b_m;
            5'd2:  res = ~A & mask;
            5'd3:  res = ~B & mask;
            5'd4, 5'd5, 5'd6: begin
                res      = sum[WIDTH-1:0] & mask;
                is_arith = 1'b1;
            end
            5'd7:  res = a_m & b_m;
            5'd8:  res = a_m | b_m;
            5'd9:  res = a_m ^ b_m;
            5'd10: res = ~(a_m & b_m) & mask;
            5'd11: begin res = (a_m << 1) & mask;             is_shift = 1'b1; shift_out = a_top;  end
            5'd12: begin res = a_m >> 1;                      is_shift = 1'b1; shift_out = a_m[0]; end
            5'd13: begin res = (a_m >> 1) | (a_top ? top : '0); is_shift = 1'b1; shift_out = a_m[0]; end
            5'd14: begin
                res       = ((a_m << 1) | {{(WIDTH-1){1'b0}}, c_flag}) & mask;
                is_shift  = 1'b1;
                shift_out = a_top;
            end
            5'd15: begin res = (a_m >> 1) | (c_flag ? top : '0); is_shift = 1'b1; shift_out = a_m[0]; end
            default: reserved = 1'b1;
        endcase
        ovf      = (a_top == |(b_op & top)) && (|(res & top) != a_top);
        sc_flags = {res == '0,
                    is_arith ? carry : (is_shift ? shift_out : c_flag),
                    |(res & top),
                    is_arith ? ovf : flags_q[0]};
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d, acc_nx;
    logic [WIDTH-1:0]     mplier_q, mplier_d, mmask, mtop;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mhalf_q, mhalf_d, mwf_q, mwf_d, mul_hi;

    assign is_mul = (FunSel == 5'd16);
    assign idle   = (state_q == IDLE);
    assign Busy   = (state_q == MUL);
    assign mul_wf = mwf_q;

    // One multiplier bit per cycle; the last iteration's sum is the product.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mhalf_d   = mhalf_q;
        mwf_d     = mwf_q;
        mul_done  = 1'b0;
        mmask     = mhalf_q ? HALF_MASK : '1;
        mtop      = mhalf_q ? TOP_HALF : TOP_FULL;
        acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_res   = acc_nx[WIDTH-1:0] & mmask;
        mul_hi    = mhalf_q ? (|acc_nx[2*WIDTH-1:H]) : (|acc_nx[2*WIDTH-1:WIDTH]);
        mul_flags = {mul_res == '0, mul_hi, |(mul_res & mtop), mul_hi};
        if (state_q == IDLE) begin
            if (accept && is_mul) begin
                state_d  = MUL;
                mcand_d  = {{WIDTH{1'b0}}, a_m};
                mplier_d = b_m;
                acc_d    = '0;
                cnt_d    = Half ? CNT_HALF : CNT_FULL;
                mhalf_d  = Half;
                mwf_d    = WF;
            end
        end else begin
            acc_d    = acc_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                mul_done = 1'b1;
                state_d  = IDLE;
            end
        end
    end
`else
    assign is_mul    = 1'b0;
    assign idle      = 1'b1;
    assign Busy      = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_wf    = 1'b0;
    assign mul_res   = '0;
    assign mul_flags = '0;
`endif

    always_comb begin
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q & ~OutReady;
        if (accept && !is_mul) begin
            alu_out_d   = res;
            out_valid_d = 1'b1;
            if (WF && !reserved) flags_d = sc_flags;
        end
        if (mul_done) begin
            alu_out_d   = mul_res;
            out_valid_d = 1'b1;
            if (mul_wf) flags_d = mul_flags;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            alu_out_q   <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mhalf_q     <= 1'b0;
            mwf_q       <= 1'b0;
`endif
        end else begin
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mhalf_q     <= mhalf_d;
            mwf_q       <= mwf_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: directed and randomized checks of alu_stream against an arithmetic reference model.
module tb_alu_stream;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset, InValid, InReady, Half, WF, OutValid, OutReady, Busy;
    logic [15:0] A, B, ALUOut;
    logic [4:0]  FunSel;
    logic [3:0]  FlagsOut;

    logic [3:0]  mflags;
    int          n_cmp = 0;
    int          n_err = 0;

    alu_stream #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .FunSel(FunSel), .Half(Half), .WF(WF),
        .OutValid(OutValid), .OutReady(OutReady), .ALUOut(ALUOut),
        .FlagsOut(FlagsOut), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: values as unsigned integers modulo 2^M, signed view for overflow.
    function automatic logic [15:0] ref_op(input int f, input longint a, input longint b,
                                           input bit h, input bit wf);
        longint md, av, bv, sa, sb, r, p, cin, s;
        bit c, o, upd;
        md  = h ? 256 : 65536;
        av  = a % md;
        bv  = b % md;
        sa  = (av >= md / 2) ? av - md : av;
        sb  = (bv >= md / 2) ? bv - md : bv;
        c   = mflags[2];
        o   = mflags[0];
        upd = 1'b1;
        cin = 0;
        r   = av;
        case (f)
            0:  r = av;
            1:  r = bv;
            2:  r = md - 1 - av;
            3:  r = md - 1 - bv;
            4, 5: begin
                cin = (f == 5) ? longint'(mflags[2]) : 0;
                r = av + bv + cin;
                s = sa + sb + cin;
                c = (r >= md);
                o = (s >= md / 2) || (s < -(md / 2));
                r = r % md;
            end
            6: begin
                r = av - bv;
                s = sa - sb;
                c = (av >= bv);
                o = (s >= md / 2) || (s < -(md / 2));
                if (r < 0) r = r + md;
            end
            7:  r = av & bv;
            8:  r = av | bv;
            9:  r = av ^ bv;
            10: r = md - 1 - (av & bv);
            11: begin r = (av * 2) % md; c = (av >= md / 2); end
            12: begin r = av / 2; c = av[0]; end
            13: begin r = av / 2 + ((av >= md / 2) ? md / 2 : 0); c = av[0]; end
            14: begin r = (av * 2) % md + longint'(mflags[2]); c = (av >= md / 2); end
            15: begin r = av / 2 + (mflags[2] ? md / 2 : 0); c = av[0]; end
            16: begin
                if (MUL_EN) begin
                    p = av * bv;
                    r = p % md;
                    c = (p >= md);
                    o = c;
                end else begin
                    upd = 1'b0;
                end
            end
            default: upd = 1'b0;
        endcase
        if (wf && upd) mflags = {r == 0, c, r >= md / 2, o};
        return r[15:0];
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && !InReady; i++) @(negedge Clock);
        chk({tag, ":ready"}, InReady, 1);
    endtask

    // Issue one op with OutReady high; returns at the sample where its result is visible.
    task automatic run_op(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                          input logic h, input logic wf, input string tag);
        logic [15:0] er;
        logic [3:0]  ef;
        int          ncyc;
        ncyc = (MUL_EN && f == 5'd16) ? (h ? 8 : 16) : 0;
        @(negedge Clock);
        OutReady = 1'b1;
        InValid = 1'b1; FunSel = f; A = a; B = b; Half = h; WF = wf;
        wait_ready(tag);
        er = ref_op(int'(f), longint'(a), longint'(b), h, wf);
        ef = mflags;
        @(negedge Clock);
        InValid = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; FunSel = 5'd9;
        for (int i = 0; i < ncyc; i++) begin
            chk({tag, ":busy"}, {Busy, InReady, OutValid}, 3'b100);
            @(negedge Clock);
        end
        chk({tag, ":vld"}, {OutValid, Busy}, 2'b10);
        chk({tag, ":res"}, ALUOut, er);
        chk({tag, ":flg"}, FlagsOut, ef);
    endtask

    initial begin
        logic [15:0] er;
        logic [3:0]  ef;
        logic        seen;
        logic [4:0]  f;
        Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1; A = '0; B = '0;
        FunSel = '0; Half = 1'b0; WF = 1'b0;
        mflags = 4'b0000;
        repeat (2) @(negedge Clock);
        chk("rst", {ALUOut, FlagsOut, OutValid, Busy}, 22'd0);
        Reset = 1'b1;

        run_op(5'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b1, "add_ovf");
        chk("add_ovf_k", {ALUOut, FlagsOut}, {16'h8000, 4'b0011});
        run_op(5'd6, 16'h0005, 16'h0007, 1'b0, 1'b1, "sub_brw");
        chk("sub_brw_k", {ALUOut, FlagsOut}, {16'hFFFE, 4'b0010});
        run_op(5'd5, 16'h0001, 16'h0001, 1'b0, 1'b0, "adc_nowf");
        chk("adc_nowf_k", {ALUOut, FlagsOut}, {16'h0002, 4'b0010});
        run_op(5'd4, 16'h12FF, 16'h0001, 1'b1, 1'b1, "hadd");
        chk("hadd_k", {ALUOut, FlagsOut}, {16'h0000, 4'b1100});
        run_op(5'd14, 16'h0040, 16'h0000, 1'b1, 1'b1, "hrcl");
        chk("hrcl_k", {ALUOut, FlagsOut}, {16'h0081, 4'b0010});
        run_op(5'd16, 16'h0100, 16'h0100, 1'b0, 1'b1, "mul");
        chk("mul_k", {ALUOut, FlagsOut}, MUL_EN ? {16'h0000, 4'b1101} : {16'h0100, 4'b0010});
        run_op(5'd20, 16'hA5A5, 16'h1234, 1'b1, 1'b1, "resv");
        chk("resv_k", ALUOut, 16'h00A5);

        // Backpressure: result held, new request ignored until consumed.
        run_op(5'd4, 16'h0003, 16'h0004, 1'b0, 1'b1, "stall_add");
        OutReady = 1'b0;
        InValid = 1'b1; FunSel = 5'd6; A = 16'h1111; B = 16'h2222; WF = 1'b1; Half = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("stall_hold", {ALUOut, OutValid, InReady}, {16'h0007, 1'b1, 1'b0});
        end
        FunSel = 5'd9; A = 16'hF0F0; B = 16'h0FF0;
        OutReady = 1'b1;
        er = ref_op(9, 16'hF0F0, 16'h0FF0, 1'b0, 1'b1);
        ef = mflags;
        @(negedge Clock);
        InValid = 1'b0;
        chk("stall_swap", {ALUOut, FlagsOut, OutValid}, {er, ef, 1'b1});
        @(negedge Clock);
        chk("stall_drain", OutValid, 0);

        // Random ops, operands and precision.
        for (int n = 0; n < 250; n++) begin
            f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            run_op(f, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d_f%0d", n, f));
        end

        // Reset during a multiply.
        @(negedge Clock);
        InValid = 1'b1; FunSel = 5'd16; A = 16'h00FF; B = 16'h00FF; Half = 1'b0; WF = 1'b1;
        wait_ready("rst_mul");
        @(negedge Clock);
        InValid = 1'b0;
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b0;
        #1 chk("rst_mid", {ALUOut, FlagsOut, OutValid, Busy}, 22'd0);
        @(negedge Clock);
        Reset = 1'b1;
        mflags = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (OutValid) seen = 1'b1;
        end
        chk("rst_noresult", seen, 0);
        run_op(5'd4, 16'h0001, 16'h0001, 1'b0, 1'b1, "post_rst");
        chk("post_rst_k", {ALUOut, FlagsOut}, {16'h0002, 4'b0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_stream.md
# alu_stream

Parametrised, handshaked successor to the datapath ALU. It registers its result and its Z/C/N/O flags, and runs every operation at WIDTH or WIDTH/2 precision under a separate half-width select. An optional multi-cycle shift-add multiplier is included. It sits between the register-file read ports and the write-back mux, and accepts one operation per cycle through a valid/ready pair.

## Interface
- WIDTH, 16: operand/result width; even, ≥4
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- InValid  in  1  operation request
- InReady  out  1  combinational; high = request accepted this edge if InValid
- A, B  in  WIDTH  operands
- FunSel  in  5  operation code (see Operation)
- Half  in  1  1 = operate on low WIDTH/2 bits
- WF  in  1  1 = commit flags of this operation
- OutValid  out  1  ALUOut holds an unconsumed result
- OutReady  in  1  consumer takes result when OutValid & OutReady
- ALUOut  out  WIDTH  registered result
- FlagsOut  out  4  registered flags {Z,C,N,O} = [3:0]
- Busy  out  1  multiplier iterating

## Operation
- FunSel: 0 A, 1 B, 2 ~A, 3 ~B, 4 ADD, 5 ADC (A+B+C), 6 SUB (A+~B+1), 7 AND, 8 OR, 9 XOR, 10 NAND, 11 LSL, 12 LSR, 13 ASR, 14 RCL {A[M-2:0],C}, 15 RCR {C,A[M-1:1]}, 16 MUL (multi-cycle), 17–31 reserved.
- M = WIDTH when Half=0, WIDTH/2 when Half=1. Only bits [M-1:0] of A and B are used. ALUOut[WIDTH-1:M] is 0 in half mode.
- Z = result[M-1:0]==0 and N = result[M-1] on all non-reserved ops.
- C: carry-out of bit M-1 for ADD/ADC/SUB (SUB: C=1 means no borrow). Shifted-out bit for LSL/LSR/ASR/RCL/RCR. Unchanged for all other ops.
- O: signed overflow for ADD/ADC/SUB. Unchanged for all other ops.
- ADC, RCL and RCR read the C in FlagsOut at the accept edge.
- WF=0: FlagsOut is unchanged; the result is still produced.
- Reserved ops: ALUOut = A masked to M bits, FlagsOut unchanged regardless of WF.
- MUL: unsigned shift-add over M iterations, one bit per cycle.
  - ALUOut = low M bits of the product.
  - C = O = 1 when the product's upper M bits are nonzero.
- FSM:
  - IDLE: single-cycle ops complete at the accept edge. Accepting MUL latches operands, clears the accumulator and moves to MUL.
  - MUL: one iteration per cycle, then returns to IDLE. On the final edge it writes ALUOut and the flags (if WF) and sets OutValid.

## Timing
- Reset values: ALUOut=0, FlagsOut=4'b0000, OutValid=0, Busy=0, state IDLE.
- InReady = (state==IDLE) & (!OutValid | OutReady).
- Single-cycle op accepted at edge k: ALUOut, FlagsOut and OutValid are valid after edge k (latency 1). Back-to-back accepts at full rate when OutReady=1. An op accepted at k+1 sees the flags committed at k.
- MUL accepted at edge k: Busy=1 after edge k. The result and OutValid appear after edge k+M, and Busy drops on that same edge. InReady is low throughout.
- OutValid clears on an edge with OutReady=1 and no new completion. A simultaneous consume and completion leaves OutValid=1 with the new data.
- While OutValid=1 and OutReady=0, ALUOut and FlagsOut hold and InReady=0.
- Reset asserted mid-MUL: immediately aborts, outputs go to reset values, no result is produced.
- Operand or FunSel changes while InReady=0 are ignored.

## Configuration
- ALU_MUL_EN defined: MUL (FunSel 16) and the MUL state are compiled in.
- ALU_MUL_EN undefined: FunSel 16 behaves as reserved (single cycle), and Busy is tied to 0.

## Test plan
- WIDTH=16, ADD A=0x7FFF B=0x0001 WF=1 -> ALUOut=0x8000, FlagsOut=4'b0011, OutValid one cycle after accept.
- SUB A=0x0005 B=0x0007 WF=1 -> ALUOut=0xFFFE, FlagsOut=4'b0010. Then ADC A=0x0001 B=0x0001 WF=0 -> ALUOut=0x0002, FlagsOut still 4'b0010.
- Half=1, ADD A=0x12FF B=0x0001 WF=1 -> ALUOut=0x0000, FlagsOut=4'b1100. Then RCL A=0x0040 Half=1 -> ALUOut=0x0081, FlagsOut=4'b0010.
- MUL A=0x0100 B=0x0100 WF=1 (ALU_MUL_EN) -> InReady=0 and Busy=1 for 16 cycles; then ALUOut=0x0000, FlagsOut=4'b1101. Without the macro, same stimulus -> ALUOut=0x0100, FlagsOut unchanged, latency 1.
- OutReady=0 after an ADD result -> ALUOut held and InReady=0 for 5 cycles. OutReady=1 and InValid=1 on the same edge -> next result replaces it, OutValid stays 1.
- Reset deasserted→asserted 4 cycles into MUL -> all outputs at reset values next sample, OutValid never rises. After release, ADD 0x0001+0x0001 completes normally.
